// File: rtl/heptagon_area_acc.sv
// rtl/heptagon_area_acc.sv - streaming shoelace area accumulator, seven vertices per object
// Emits one saturated |area| per object and flags frame_done after OBJ_N objects.
module heptagon_area_acc #(
  parameter int OBJ_N  = 5,
  parameter int AREA_W = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [9:0]        X,
  input  logic [9:0]        Y,
  output logic              area_valid,
  output logic [AREA_W-1:0] area,
  output logic [2:0]        area_index,
  output logic              frame_done
);

  localparam logic [22:0] AREA_MAX = 23'((1 << AREA_W) - 1);

  logic [2:0]         vcnt;
  logic [2:0]         ocnt;
  logic [9:0]         first_x, first_y, prev_x, prev_y;
  logic signed [23:0] acc, sum_r;
  logic               pend, done;

  logic               accept;
  logic [19:0]        p_edge_a, p_edge_b, p_close_a, p_close_b;
  logic signed [23:0] edge_term, close_term;
  logic [23:0]        mag;
  logic [22:0]        half;

  always_comb begin
    accept     = in_valid & ~done;
    p_edge_a   = prev_x * Y;
    p_edge_b   = X * prev_y;
    p_close_a  = X * first_y;
    p_close_b  = first_x * Y;
    // Products are unsigned; widen with zeros before the signed difference.
    edge_term  = $signed({4'd0, p_edge_a}) - $signed({4'd0, p_edge_b});
    close_term = $signed({4'd0, p_close_a}) - $signed({4'd0, p_close_b});
    mag        = sum_r[23] ? 24'(-sum_r) : 24'(sum_r);
    half       = mag[23:1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vcnt       <= '0;
      ocnt       <= '0;
      first_x    <= '0;
      first_y    <= '0;
      prev_x     <= '0;
      prev_y     <= '0;
      acc        <= '0;
      sum_r      <= '0;
      pend       <= 1'b0;
      done       <= 1'b0;
      area_valid <= 1'b0;
      area       <= '0;
      area_index <= '0;
      frame_done <= 1'b0;
    end else begin
      area_valid <= 1'b0;
      // Output stage runs alongside vertex 0 of the next object.
      if (pend) begin
        area       <= (half > AREA_MAX) ? AREA_MAX[AREA_W-1:0] : half[AREA_W-1:0];
        area_index <= ocnt;
        area_valid <= 1'b1;
        pend       <= 1'b0;
        if (ocnt == 3'(OBJ_N - 1)) begin
          ocnt       <= '0;
          done       <= 1'b1;
          frame_done <= 1'b1;
        end else begin
          ocnt <= ocnt + 3'd1;
        end
      end
      if (accept) begin
        if (vcnt == 3'd0) begin
          first_x <= X;
          first_y <= Y;
          prev_x  <= X;
          prev_y  <= Y;
          acc     <= '0;
          vcnt    <= 3'd1;
        end else if (vcnt == 3'd6) begin
          sum_r <= acc + edge_term + close_term;
          pend  <= 1'b1;
          vcnt  <= 3'd0;
        end else begin
          acc    <= acc + edge_term;
          prev_x <= X;
          prev_y <= Y;
          vcnt   <= vcnt + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_heptagon_area_acc.sv
// tb/tb_heptagon_area_acc.sv - scoreboard bench for heptagon_area_acc
// Driver queues expected (index, area, frame_done, cycle); a negedge monitor pops on each pulse.
module tb_heptagon_area_acc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [9:0]  X = '0;
  logic [9:0]  Y = '0;
  logic        area_valid;
  logic [18:0] area;
  logic [2:0]  area_index;
  logic        frame_done;

  heptagon_area_acc #(.OBJ_N(5), .AREA_W(19)) dut (
    .clk(clk), .reset(rst_n), .in_valid(in_valid), .X(X), .Y(Y),
    .area_valid(area_valid), .area(area), .area_index(area_index), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int ar;
    int fd;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;

  // Object table: 0 CCW, 1 CW, 2 floor case, 3 saturating
  int vx[4][7] = '{'{0, 4, 6, 6, 3, 0, 0}, '{0, 0, 3, 6, 6, 4, 0},
                   '{0, 4, 6, 6, 3, 0, 1}, '{0, 511, 1023, 1023, 1023, 0, 0}};
  int vy[4][7] = '{'{0, 0, 2, 5, 7, 5, 2}, '{2, 5, 7, 5, 2, 0, 0},
                   '{0, 0, 2, 5, 7, 5, 2}, '{0, 0, 0, 511, 1023, 1023, 511}};
  int va[4]    = '{34, 34, 31, 524287};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && area_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_pulse: got index %0d area %0d, expected no pulse", area_index, area);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("area_index", int'(area_index), e.idx);
        check("area", int'(area), e.ar);
        check("frame_done_at_pulse", int'(frame_done), e.fd);
        check("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic send_vtx(input int x, input int y);
    @(negedge clk);
    in_valid = 1'b1;
    X = 10'(x);
    Y = 10'(y);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic send_obj(input int o, input int gap_at, input int gap_len, input int idx, input int fd);
    for (int v = 0; v < 7; v++) begin
      if (v == gap_at) idle(gap_len);
      send_vtx(vx[o][v], vy[o][v]);
      if (v == 6) exp_q.push_back('{idx, va[o], fd, cyc + 2});
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_area_valid"}, int'(area_valid), 0);
    check({tag, "_area"}, int'(area), 0);
    check({tag, "_area_index"}, int'(area_index), 0);
    check({tag, "_frame_done"}, int'(frame_done), 0);
  endtask

  task automatic post_frame_ignore(input int last_area);
    idle(2);
    for (int v = 0; v < 7; v++) send_vtx(vx[3][v], vy[3][v]);
    idle(4);
    check("frame_done_held", int'(frame_done), 1);
    check("area_held", int'(area), last_area);
    check("index_held", int'(area_index), 4);
  endtask

  initial begin
    #1;
    check_zero_outputs("reset");
    in_valid = 1'b1;
    X = 10'd5;
    Y = 10'd5;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;

    // Frame A: back-to-back, last object has a 3-cycle gap between vertices 2 and 3
    send_obj(0, -1, 0, 0, 0);
    send_obj(1, -1, 0, 1, 0);
    send_obj(2, -1, 0, 2, 0);
    send_obj(3, -1, 0, 3, 0);
    send_obj(0, 3, 3, 4, 1);
    idle(4);
    check("frameA_drained", exp_q.size(), 0);
    post_frame_ignore(34);

    // Frame B: abort after vertex 4 of object 1 with an asynchronous reset
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send_obj(0, -1, 0, 0, 0);
    for (int v = 0; v < 5; v++) send_vtx(vx[1][v], vy[1][v]);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    in_valid = 1'b0;
    idle(2);
    rst_n = 1'b1;

    // Frame C: five objects with no gaps after the abort
    send_obj(2, -1, 0, 0, 0);
    send_obj(3, -1, 0, 1, 0);
    send_obj(1, -1, 0, 2, 0);
    send_obj(0, -1, 0, 3, 0);
    send_obj(0, -1, 0, 4, 1);
    idle(4);
    check("frameC_drained", exp_q.size(), 0);
    post_frame_ignore(34);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/heptagon_area_acc.md
# heptagon_area_acc

Streaming shoelace-area accumulator for the heptagon sorting datapath. It sits directly upstream of the area sorter. It takes one (X, Y) vertex per cycle, seven consecutive vertices per object, in boundary order (CW or CCW). For each object it emits one (index, area) pair, where area is the absolute polygon area. After OBJ_N objects it raises a frame-done flag and idles until reset.

## Interface
- OBJ_N, 5, objects per frame; object index counts 0..OBJ_N-1
- AREA_W, 19, output area width; the result saturates at 2^AREA_W-1
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- in_valid  in  1  X/Y carry a vertex this cycle
- X  in  10  vertex x, unsigned
- Y  in  10  vertex y, unsigned
- area_valid  out  1  one-cycle pulse; area/area_index valid
- area  out  AREA_W  floor(|doubled area| / 2), saturated
- area_index  out  3  object index, 0-based, in arrival order
- frame_done  out  1  high once OBJ_N areas have been emitted; held until reset

## Operation
- State registers:
  - vcnt: 0..6, vertex within the object.
  - ocnt: 0..OBJ_N-1.
  - first_x/first_y: vertex 0 of the current object.
  - prev_x/prev_y: the last accepted vertex.
  - acc: 24-bit signed accumulator.
  - sum_r: 24-bit signed.
  - pend: 1 bit.
  - done: 1 bit.
- Vertex accepted when in_valid=1 and done=0. Otherwise inputs are ignored and state is held.
- Accepted vertex, by vcnt:
  - vcnt=0: store first and prev; acc<=0.
  - vcnt=1..5: acc<=acc+(prev_x*Y - X*prev_y); prev<=X/Y.
  - vcnt=6: sum_r <= acc + (prev_x*Y - X*prev_y) + (X*first_y - first_x*Y); pend<=1; vcnt<=0.
- vcnt increments per accepted vertex and wraps 6->0.
- Arithmetic:
  - Products are unsigned 20-bit, zero-extended to 24-bit signed before subtraction.
  - Worst-case partial sum magnitude is below 2^23, so no overflow.
- Output stage, the cycle after pend=1:
  - area <= min(|sum_r| >> 1, 2^AREA_W-1).
  - area_index <= ocnt.
  - area_valid <= 1; pend <= 0.
  - ocnt increments.
  - If ocnt was OBJ_N-1: done<=1, frame_done<=1, ocnt<=0.
- Odd doubled sums truncate (floor). Sign is discarded, so orientation does not matter.
- Back-to-back objects run without a stall. Vertex 0 of object n+1 may be accepted in the same cycle that object n is in the output stage.
- Gaps (in_valid=0) inside an object are allowed: state is held and no partial result is emitted.
- Reset values: area_valid=0, area=0, area_index=0, frame_done=0. All counters, acc, sum_r, pend and done are also 0.
- Reset mid-object discards the partial object. The next accepted vertex is vertex 0 of object 0.

## Timing
- Vertex 6 is sampled at edge k.
- sum_r is valid after edge k.
- area_valid is high for exactly one cycle, between edge k+1 and edge k+2.
- Latency from the last vertex to the result is 2 edges.
- Throughput: one object per 7 cycles sustained.
- frame_done rises at the same edge as the final area_valid.
- After frame_done, in_valid has no effect until reset is asserted and released.
- Reset is asynchronous on assertion. Release is sampled at the next rising edge; the first vertex can be accepted at the first edge with reset=1.

## Test plan
- CCW heptagon (0,0),(4,0),(6,2),(6,5),(3,7),(0,5),(0,2) as object 0 -> area_valid pulse 2 edges after the last vertex, area=34, area_index=0.
- Same seven vertices in reverse (CW) order -> area=34. Replacing (0,2) with (1,2) -> doubled sum 63, area=31 (floor check).
- Saturation: (0,0),(511,0),(1023,0),(1023,511),(1023,1023),(0,1023),(0,511) -> true area 1046529, area=524287.
- Five objects streamed back-to-back with no gaps -> five single-cycle pulses spaced 7 cycles apart, area_index 0..4. frame_done=1 with the fifth pulse and held; further in_valid is ignored, with no pulses and no state change.
- in_valid low for 3 cycles between vertices 2 and 3 -> same area as the gap-free run, with the pulse delayed 3 cycles.
- reset=0 asserted after vertex 4 of object 1, then released -> all outputs are 0 immediately. The next object reports area_index=0 and the correct area, with no residue from the aborted object.
